// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and defaults for the instruction/data memory
//                arbiter: FSM state encoding, transaction owner encoding,
//                default widths and limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Default bus widths and limits
    localparam int unsigned c_DEF_ADDR_W       = 16;
    localparam int unsigned c_DEF_DATA_W       = 16;
    localparam int unsigned c_DEF_STARVE_LIMIT = 4;
    localparam int unsigned c_DEF_TIMEOUT      = 64;

    // Arbiter FSM states, explicitly encoded
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Owner of the transaction currently in flight
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_watchdog
//  Description : BUSY-phase timeout counter for mem_arbiter. Counts cycles
//                spent waiting for memory and flags expiry on the last
//                allowed cycle when no ready strobe is present.
//                Instantiated only when MEM_ARB_WATCHDOG_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_busy,
    input  logic i_ready,
    output logic o_expire
);

    localparam int unsigned     c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Count BUSY cycles; the count restarts from zero on every BUSY entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_busy) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // The TIMEOUT-th BUSY cycle without ready ends the wait
    assign o_expire = i_busy && !i_ready && (r_cnt == c_LAST);

endmodule : mem_arb_watchdog
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Single-port memory arbiter between an instruction-fetch
//                requester and a data requester. One transaction in flight,
//                data has priority, fetch is protected from starvation by a
//                saturating counter of data grants made while fetch waits.
//                Optional BUSY watchdog enabled by MEM_ARB_WATCHDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = c_DEF_ADDR_W,
    parameter int unsigned DATA_W       = c_DEF_DATA_W,
    parameter int unsigned STARVE_LIMIT = c_DEF_STARVE_LIMIT,
    parameter int unsigned TIMEOUT      = c_DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    // data port
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    // memory port
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    // status
    output logic              err
);

    localparam int unsigned c_STARVE_W =
        (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    // Reject parameter values the counters cannot represent
    generate
        if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
            $error("mem_arbiter: STARVE_LIMIT must be at least 1");
        end
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("mem_arbiter: TIMEOUT must be at least 2");
        end
    endgenerate

    arb_state_t              r_state;
    owner_t                  r_owner;
    logic [ADDR_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic                    r_wr;
    logic                    r_mem_req;
    logic                    r_i_done;
    logic                    r_d_done;
    logic [DATA_W-1:0]       r_i_rdata;
    logic [DATA_W-1:0]       r_d_rdata;
    logic [c_STARVE_W-1:0]   r_starve_cnt;

    logic                    w_d_any;
    logic                    w_grant_i;
    logic                    w_timeout;
    logic [DATA_W-1:0]       w_resp_data;

    assign w_d_any = d_rd | d_wr;

    // Fetch wins when it is alone or when data has used up its allowance
    assign w_grant_i = i_req && (!w_d_any || (r_starve_cnt == c_STARVE_MAX));

    // A timed-out transaction returns zero instead of memory data
    assign w_resp_data = mem_ready ? mem_rdata : '0;

`ifdef MEM_ARB_WATCHDOG_EN
    logic w_busy;
    logic r_err;

    assign w_busy = (r_state == ST_BUSY);

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_busy   (w_busy),
        .i_ready  (mem_ready),
        .o_expire (w_timeout)
    );

    // Timeout error stays set until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // Arbiter FSM: grant in IDLE, wait for memory in BUSY, pulse done in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_I;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wr         <= 1'b0;
            r_mem_req    <= 1'b0;
            r_i_done     <= 1'b0;
            r_d_done     <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_mem_req <= 1'b0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req || w_d_any) begin
                        r_state   <= ST_BUSY;
                        r_mem_req <= 1'b1;
                        if (w_grant_i) begin
                            r_owner      <= OWN_I;
                            r_addr       <= i_addr;
                            r_wdata      <= '0;
                            r_wr         <= 1'b0;
                            r_starve_cnt <= '0;
                        end else begin
                            r_owner <= OWN_D;
                            r_addr  <= d_addr;
                            r_wdata <= d_wdata;
                            // read+write together is a write
                            r_wr    <= d_wr;
                            if (i_req && (r_starve_cnt != c_STARVE_MAX)) begin
                                r_starve_cnt <= r_starve_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ready || w_timeout) begin
                        r_state <= ST_RESP;
                        if (r_owner == OWN_I) begin
                            r_i_done  <= 1'b1;
                            r_i_rdata <= w_resp_data;
                        end else begin
                            r_d_done  <= 1'b1;
                            r_d_rdata <= w_resp_data;
                        end
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_wr    = r_wr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign i_done    = r_i_done;
    assign i_rdata   = r_i_rdata;
    assign d_done    = r_d_done;
    assign d_rdata   = r_d_rdata;

    assign i_stall   = i_req & ~r_i_done;
    assign d_stall   = w_d_any & ~r_d_done;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Expected memory
//                commands and completions are queued as stimulus is issued
//                and compared when the DUT presents them. A behavioural
//                memory answers mem_req with rdata = addr + 0x11F4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int unsigned c_AW  = 16;
    localparam int unsigned c_DW  = 16;
    localparam logic [15:0] c_OFS = 16'h11F4;

    typedef struct {
        logic        is_d;
        logic [15:0] addr;
        logic        wr;
        logic [15:0] wdata;
    } cmd_t;

    typedef struct {
        logic        is_d;
        logic [15:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_req = 1'b0;
    logic [c_AW-1:0] i_addr = '0;
    logic i_done;
    logic [c_DW-1:0] i_rdata;
    logic i_stall;
    logic d_rd = 1'b0;
    logic d_wr = 1'b0;
    logic [c_AW-1:0] d_addr = '0;
    logic [c_DW-1:0] d_wdata = '0;
    logic d_done;
    logic [c_DW-1:0] d_rdata;
    logic d_stall;
    logic mem_req;
    logic mem_wr;
    logic [c_AW-1:0] mem_addr;
    logic [c_DW-1:0] mem_wdata;
    logic [c_DW-1:0] mem_rdata = '0;
    logic mem_ready = 1'b0;
    logic err;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int i_cnt    = 0;
    int d_cnt    = 0;
    int i_done_cyc = -1;
    int d_done_cyc = -1;
    int req_cyc    = -1;
    int mem_lat    = 1;
    bit hang       = 1'b0;

    mem_arbiter #(
        .ADDR_W       (c_AW),
        .DATA_W       (c_DW),
        .STARVE_LIMIT (4),
        .TIMEOUT      (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .i_stall   (i_stall),
        .d_rd      (d_rd),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic expect_txn(input logic is_d, input logic [15:0] addr,
                              input logic wr, input logic [15:0] wdata,
                              input logic [15:0] rdata, input bit with_rsp);
        cmd_t c;
        rsp_t r;
        c.is_d = is_d; c.addr = addr; c.wr = wr; c.wdata = wdata;
        cmd_q.push_back(c);
        if (with_rsp) begin
            r.is_d = is_d; r.rdata = rdata;
            rsp_q.push_back(r);
        end
    endtask

    task automatic wait_counts(input int ti, input int td, input string tag);
        int k = 0;
        while ((i_cnt < ti || d_cnt < td) && k < 300) begin
            @(posedge clk); #2;
            k++;
        end
        check({tag, "_wait"}, 32'((i_cnt >= ti) && (d_cnt >= td)), 32'd1);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    // Memory model: checks each command against the queue and answers it
    initial begin
        cmd_t c;
        forever begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            if (mem_req) begin
                if (cmd_q.size() == 0) begin
                    check("unexpected_mem_req", 32'd1, 32'd0);
                end else begin
                    c = cmd_q.pop_front();
                    check("mem_addr", 32'(mem_addr), 32'(c.addr));
                    check("mem_wr", 32'(mem_wr), 32'(c.wr));
                    if (c.wr) check("mem_wdata", 32'(mem_wdata), 32'(c.wdata));
                end
                if (!hang) begin
                    repeat (mem_lat) begin @(posedge clk); #1; end
                    mem_rdata = mem_addr + c_OFS;
                    mem_ready = 1'b1;
                end
            end
        end
    end

    // Completion monitor: compares done pulses against expected responses
    initial begin
        rsp_t r;
        forever begin
            @(posedge clk); #1;
            if (mem_req) req_cyc = cyc;
            if (i_done || d_done) begin
                if (i_done) begin i_cnt++; i_done_cyc = cyc; end
                if (d_done) begin d_cnt++; d_done_cyc = cyc; end
                check("single_done", 32'(i_done & d_done), 32'd0);
                if (rsp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    check("done_owner", 32'(d_done), 32'(r.is_d));
                    check("done_rdata", 32'(d_done ? d_rdata : i_rdata), 32'(r.rdata));
                end
            end
        end
    end

    initial begin
        int n0;
        int d0;
        int i0;

        // Reset state
        step(3);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_dones", 32'({i_done, d_done}), 32'd0);
        check("rst_rdata", 32'({i_rdata, d_rdata}), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Lone fetch, memory ready one cycle after mem_req
        mem_lat = 1;
        expect_txn(1'b0, 16'h0040, 1'b0, 16'h0, 16'h1234, 1'b1);
        n0 = cyc;
        i_req = 1'b1; i_addr = 16'h0040;
        step(1);
        check("fetch_stall", 32'(i_stall), 32'd1);
        wait_counts(1, 0, "fetch");
        i_req = 1'b0;
        check("fetch_req_lat", 32'(req_cyc - n0), 32'd1);
        check("fetch_done_lat", 32'(i_done_cyc - n0), 32'd3);
        check("fetch_rdata", 32'(i_rdata), 32'h1234);
        step(1);
        check("fetch_stall_clr", 32'(i_stall), 32'd0);

        // Minimum latency data read, ready in the mem_req cycle
        mem_lat = 0;
        expect_txn(1'b1, 16'h0200, 1'b0, 16'h0, 16'h13F4, 1'b1);
        n0 = cyc;
        d_rd = 1'b1; d_addr = 16'h0200;
        wait_counts(1, 1, "minlat");
        d_rd = 1'b0;
        check("minlat_done_lat", 32'(d_done_cyc - n0), 32'd2);

        // Simultaneous fetch and data read: data first
        mem_lat = 1;
        expect_txn(1'b1, 16'h0100, 1'b0, 16'h0, 16'h12F4, 1'b1);
        expect_txn(1'b0, 16'h0080, 1'b0, 16'h0, 16'h1274, 1'b1);
        i_req = 1'b1; i_addr = 16'h0080;
        d_rd  = 1'b1; d_addr = 16'h0100;
        wait_counts(1, 2, "prio_d");
        d_rd = 1'b0;
        check("prio_i_stall", 32'(i_stall), 32'd1);
        wait_counts(2, 2, "prio_i");
        i_req = 1'b0;

        // Continuous writes with fetch waiting: 4 data grants then fetch
        d0 = d_cnt; i0 = i_cnt;
        for (int k = 0; k < 4; k++)
            expect_txn(1'b1, 16'h0300, 1'b1, 16'hA000, 16'h14F4, 1'b1);
        expect_txn(1'b0, 16'h00C0, 1'b0, 16'h0, 16'h12B4, 1'b1);
        i_req = 1'b1; i_addr = 16'h00C0;
        d_wr  = 1'b1; d_addr = 16'h0300; d_wdata = 16'hA000;
        wait_counts(i0 + 1, d0 + 4, "starve");
        i_req = 1'b0; d_wr = 1'b0;
        check("starve_d_grants", 32'(d_cnt - d0), 32'd4);
        check("starve_cnt_clr", 32'(dut.r_starve_cnt), 32'd0);
        step(1);

        // Read and write together behaves as a write
        expect_txn(1'b1, 16'h0400, 1'b1, 16'hBEEF, 16'h15F4, 1'b1);
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0400; d_wdata = 16'hBEEF;
        wait_counts(i_cnt, d_cnt + 1, "rdwr");
        d_rd = 1'b0; d_wr = 1'b0;

        // Read data holds between pulses
        step(4);
        check("hold_d_rdata", 32'(d_rdata), 32'h15F4);
        check("hold_i_rdata", 32'(i_rdata), 32'h12B4);

        // Reset while BUSY: registered outputs clear at once, no done pulse
        hang = 1'b1;
        d0 = d_cnt;
        expect_txn(1'b1, 16'h0500, 1'b0, 16'h0, 16'h0, 1'b0);
        d_rd = 1'b1; d_addr = 16'h0500;
        step(1);
        check("busy_mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_mem_req", 32'(mem_req), 32'd0);
        check("arst_mem_addr", 32'(mem_addr), 32'd0);
        check("arst_d_rdata", 32'(d_rdata), 32'd0);
        d_rd = 1'b0;
        step(3);
        check("arst_no_done", 32'(d_cnt - d0), 32'd0);
        rst_n = 1'b1;
        hang = 1'b0;
        step(1);
        expect_txn(1'b0, 16'h0600, 1'b0, 16'h0, 16'h17F4, 1'b1);
        i_req = 1'b1; i_addr = 16'h0600;
        wait_counts(i_cnt + 1, d_cnt, "post_rst");
        i_req = 1'b0;
        step(1);

`ifdef MEM_ARB_WATCHDOG_EN
        // Memory never answers: watchdog ends the transaction
        hang = 1'b1;
        expect_txn(1'b1, 16'h0700, 1'b0, 16'h0, 16'h0, 1'b1);
        n0 = cyc;
        d_rd = 1'b1; d_addr = 16'h0700;
        wait_counts(i_cnt, d_cnt + 1, "wdog");
        d_rd = 1'b0;
        check("wdog_done_lat", 32'(d_done_cyc - n0), 32'd9);
        check("wdog_err", 32'(err), 32'd1);
        hang = 1'b0;
        step(3);
        check("wdog_err_sticky", 32'(err), 32'd1);
`else
        check("err_tied", 32'(err), 32'd0);
`endif

        step(2);
        check("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
        check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule : tb_mem_arbiter
`default_nettype wire
